// File: rtl/query_issue_pkg.sv
// Shared widths for the lookup path plus the query-issue types and helpers.
// lynxTypes carries the address/PID widths used across the slice.
package lynxTypes;
  localparam int VADDR_BITS = 48;
  localparam int PID_BITS   = 6;
  localparam int PADDR_BITS = 40;
endpackage

package query_issue_pkg;
  import lynxTypes::*;

  localparam int CNT_BITS = 32;

  typedef struct packed {
    logic [VADDR_BITS-1:0] vaddr;
    logic [PID_BITS-1:0]   pid;
  } qkey_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction
endpackage

// File: rtl/query_issue_tmo_cnt.sv
// Response timeout counter: cleared on load, counts while enabled, and
// flags expiry in the cycle it sits at TMO_CYCLES-1.
module query_tmo_cnt #(
  parameter int TMO_CYCLES = 1024
) (
  input  logic aclk,
  input  logic areset,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TMO_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                 cnt <= '0;
    else if (load)              cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + CW'(1);
  end

  assign expired = en && (cnt == LAST);
endmodule

// File: rtl/query_issue.sv
// Issues a mapping-table lookup whenever the {vaddr,pid} query changes,
// waits for the response or a timeout, and publishes the result and stats.
module query_issue
  import lynxTypes::*;
  import query_issue_pkg::*;
#(
  parameter int TMO_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [VADDR_BITS-1:0] vaddr,
  input  logic [PID_BITS-1:0]   pid,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [VADDR_BITS-1:0] req_vaddr,
  output logic [PID_BITS-1:0]   req_pid,
  input  logic                  resp_valid,
  input  logic                  resp_hit,
  input  logic [PADDR_BITS-1:0] resp_paddr,
  output logic                  res_done,
  output logic                  res_hit,
  output logic                  res_tmo,
  output logic [PADDR_BITS-1:0] res_paddr,
  output logic [CNT_BITS-1:0]   cnt_query,
  output logic [CNT_BITS-1:0]   cnt_miss,
  output logic [CNT_BITS-1:0]   cnt_tmo
);
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t state, state_nxt;
  qkey_t  cur, shadow;
  logic   pending, trigger, hs, tmo_exp;
  logic   start, fin_resp, fin_tmo;

  assign cur      = {vaddr, pid};
  assign trigger  = (cur != shadow);
  assign hs       = req_valid && req_ready;
  assign start    = (state == ST_IDLE) && pending;
  assign fin_resp = (state == ST_WAIT) && resp_valid;
  // A response arriving on the expiry cycle takes precedence over the timeout.
  assign fin_tmo  = (state == ST_WAIT) && !resp_valid && tmo_exp;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pending)             state_nxt = ST_REQ;
      ST_REQ:  if (hs)                  state_nxt = ST_WAIT;
      ST_WAIT: if (fin_resp || fin_tmo) state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Leaving IDLE clears pending: the issued key is this cycle's input, so a
  // change seen in the same cycle is already covered by the latch.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      shadow <= cur;
      if (start)        pending <= 1'b0;
      else if (trigger) pending <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      req_valid <= 1'b0;
      req_vaddr <= '0;
      req_pid   <= '0;
    end else if (start) begin
      req_valid <= 1'b1;
      req_vaddr <= cur.vaddr;
      req_pid   <= cur.pid;
    end else if (hs) begin
      req_valid <= 1'b0;
    end
  end

  query_tmo_cnt #(.TMO_CYCLES(TMO_CYCLES)) u_tmo (
    .aclk    (aclk),
    .areset  (areset),
    .load    (hs),
    .en      (state == ST_WAIT),
    .expired (tmo_exp)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      res_done  <= 1'b0;
      res_hit   <= 1'b0;
      res_tmo   <= 1'b0;
      res_paddr <= '0;
    end else if (start) begin
      res_done <= 1'b0;
      res_hit  <= 1'b0;
      res_tmo  <= 1'b0;
    end else if (fin_resp) begin
      res_done  <= 1'b1;
      res_hit   <= resp_hit;
      res_tmo   <= 1'b0;
      res_paddr <= resp_hit ? resp_paddr : '0;
    end else if (fin_tmo) begin
      res_done  <= 1'b1;
      res_hit   <= 1'b0;
      res_tmo   <= 1'b1;
      res_paddr <= '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_query <= '0;
      cnt_miss  <= '0;
      cnt_tmo   <= '0;
    end else begin
      if (start)                 cnt_query <= sat_inc(cnt_query);
      if (fin_resp && !resp_hit) cnt_miss  <= sat_inc(cnt_miss);
      if (fin_tmo)               cnt_tmo   <= sat_inc(cnt_tmo);
    end
  end
endmodule

// File: tb/tb_query_issue.sv
// Scoreboard bench for query_issue: driver pushes expected requests/results,
// independent monitors pop and compare on handshakes and result completion.
module tb_query_issue;
  import lynxTypes::*;

  localparam int TMO = 16;
  localparam int KW  = VADDR_BITS + PID_BITS;

  logic                  aclk = 1'b0;
  logic                  areset;
  logic [VADDR_BITS-1:0] vaddr;
  logic [PID_BITS-1:0]   pid;
  logic                  req_valid, req_ready;
  logic [VADDR_BITS-1:0] req_vaddr;
  logic [PID_BITS-1:0]   req_pid;
  logic                  resp_valid, resp_hit;
  logic [PADDR_BITS-1:0] resp_paddr;
  logic                  res_done, res_hit, res_tmo;
  logic [PADDR_BITS-1:0] res_paddr;
  logic [31:0]           cnt_query, cnt_miss, cnt_tmo;

  query_issue #(.TMO_CYCLES(TMO)) dut (
    .aclk(aclk), .areset(areset), .vaddr(vaddr), .pid(pid),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_pid(req_pid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_paddr(resp_paddr),
    .res_done(res_done), .res_hit(res_hit), .res_tmo(res_tmo), .res_paddr(res_paddr),
    .cnt_query(cnt_query), .cnt_miss(cnt_miss), .cnt_tmo(cnt_tmo)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic                  hit;
    logic                  tmo;
    logic [PADDR_BITS-1:0] paddr;
    int unsigned           cq, cm, ct;
  } exp_res_t;

  exp_res_t        exp_res[$];
  logic [KW-1:0]   exp_req[$];
  int              n_cmp = 0, n_err = 0;
  int unsigned     mq = 0, mm = 0, mt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request monitor: every handshake must match the next expected key.
  initial begin
    logic [KW-1:0] k;
    forever begin
      @(negedge aclk);
      if (!areset && req_valid && req_ready) begin
        if (exp_req.size() == 0) chk("req_unexpected", 64'(1), 64'(0));
        else begin
          k = exp_req.pop_front();
          chk("req_payload", 64'({req_vaddr, req_pid}), 64'(k));
        end
      end
    end
  end

  // Result monitor: a rising res_done must match the next expected result.
  initial begin
    bit prev_done = 1'b0;
    exp_res_t e;
    forever begin
      @(negedge aclk);
      if (areset) prev_done = 1'b0;
      else begin
        if (res_done && !prev_done) begin
          if (exp_res.size() == 0) chk("res_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_res.pop_front();
            chk("res_hit",   64'(res_hit),   64'(e.hit));
            chk("res_tmo",   64'(res_tmo),   64'(e.tmo));
            chk("res_paddr", 64'(res_paddr), 64'(e.paddr));
            chk("cnt_query", 64'(cnt_query), 64'(e.cq));
            chk("cnt_miss",  64'(cnt_miss),  64'(e.cm));
            chk("cnt_tmo",   64'(cnt_tmo),   64'(e.ct));
          end
        end
        prev_done = res_done;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},  64'(res_done), 64'(0));
    chk({tag, "_hit"},   64'(res_hit),  64'(0));
    chk({tag, "_tmo"},   64'(res_tmo),  64'(0));
    chk({tag, "_paddr"}, 64'(res_paddr), 64'(0));
    chk({tag, "_rv"},    64'(req_valid), 64'(0));
    chk({tag, "_rkey"},  64'({req_vaddr, req_pid}), 64'(0));
    chk({tag, "_cnts"},  64'({cnt_query, cnt_miss | cnt_tmo}), 64'(0));
  endtask

  task automatic start_query(input logic [VADDR_BITS-1:0] va, input logic [PID_BITS-1:0] p);
    vaddr = va;
    pid   = p;
    exp_req.push_back({va, p});
  endtask

  // Waits for req_valid (lat = cycles after the input change), stalls, then handshakes.
  task automatic handshake(input int stall, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge aclk); #1;
      lat++;
      seen = req_valid;
    end
    if (!seen) begin
      chk("req_wait_bound", 64'(0), 64'(1));
      return;
    end
    begin
      logic [KW-1:0] key = {req_vaddr, req_pid};
      for (int s = 0; s < stall; s++) begin
        @(posedge aclk); #1;
        chk("stall_valid",   64'(req_valid), 64'(1));
        chk("stall_payload", 64'({req_vaddr, req_pid}), 64'(key));
      end
    end
    req_ready = 1'b1;
    @(posedge aclk); #1;
    req_ready = 1'b0;
    mq++;
    chk("single_hs", 64'(req_valid), 64'(0));
  endtask

  // Called just after the handshake edge; j = cycles before the response strobe.
  task automatic respond(input int j, input bit do_resp, input bit hit,
                         input logic [PADDR_BITS-1:0] pa);
    exp_res_t e;
    if (do_resp) begin
      if (!hit) mm++;
      e = '{hit, 1'b0, hit ? pa : {PADDR_BITS{1'b0}}, mq, mm, mt};
    end else begin
      mt++;
      e = '{1'b0, 1'b1, {PADDR_BITS{1'b0}}, mq, mm, mt};
    end
    exp_res.push_back(e);
    if (do_resp) begin
      for (int k = 0; k < j; k++) begin @(posedge aclk); #1; end
      resp_valid = 1'b1; resp_hit = hit; resp_paddr = pa;
      @(posedge aclk); #1;
      resp_valid = 1'b0; resp_hit = 1'b0; resp_paddr = PADDR_BITS'({$urandom(), $urandom()});
    end else begin
      repeat (TMO - 1) @(posedge aclk);
      @(negedge aclk);
      chk("tmo_not_early", 64'(res_done), 64'(0));
      @(posedge aclk);
      @(negedge aclk);
      chk("tmo_on_time", 64'({res_done, res_tmo}), 64'(2'b11));
      @(posedge aclk); #1;
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 3 * TMO && !ok; k++) begin
      ok = res_done;
      if (!ok) begin @(posedge aclk); #1; end
    end
    if (!ok) chk("done_bound", 64'(0), 64'(1));
    @(posedge aclk); #1;
  endtask

  initial begin
    int lat;
    logic [VADDR_BITS-1:0] va;
    logic [PID_BITS-1:0]   p;
    logic [PADDR_BITS-1:0] pa;
    areset = 1'b1; vaddr = '0; pid = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_hit = 1'b0; resp_paddr = '0;
    repeat (2) @(posedge aclk); #1;
    chk_all_zero("reset");
    areset = 1'b0;
    repeat (2) @(posedge aclk); #1;
    chk("idle_no_req", 64'(req_valid), 64'(0));

    // Basic hit with two-cycle issue latency and result hold.
    start_query(48'h1000, 6'd3);
    handshake(0, lat);
    chk("latency", 64'(lat), 64'(2));
    respond(5, 1'b1, 1'b1, 40'hAB000);
    wait_done();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("res_hold", 64'({res_done, res_hit, res_paddr}), 64'({2'b11, 40'hAB000}));
    @(posedge aclk); #1;

    // Backpressure for 10 cycles.
    start_query(48'h1111, 6'd5);
    handshake(10, lat);
    respond(2, 1'b1, 1'b1, 40'h12345);
    wait_done();

    // Timeout with no response.
    start_query(48'h2222, 6'd7);
    handshake(0, lat);
    respond(0, 1'b0, 1'b0, '0);
    wait_done();

    // Changes during WAIT coalesce into one follow-up with the last value.
    start_query(48'h2000, 6'd1);
    handshake(0, lat);
    vaddr = 48'h3000;
    @(posedge aclk); #1;
    start_query(48'h4000, 6'd1);
    @(posedge aclk); #1;
    respond(3, 1'b1, 1'b0, 40'hDEAD);
    wait_done();
    handshake(1, lat);
    respond(1, 1'b1, 1'b1, 40'h44000);
    wait_done();

    // Miss on exactly the timeout cycle: response wins.
    start_query(48'h5555, 6'd9);
    handshake(0, lat);
    respond(TMO - 1, 1'b1, 1'b0, 40'hFFFF);
    wait_done();
    @(negedge aclk);
    chk("coinc_tmo", 64'({res_tmo, cnt_tmo}), 64'(mt));
    @(posedge aclk); #1;

    // Response strobe while idle is ignored.
    resp_valid = 1'b1; resp_hit = 1'b1; resp_paddr = 40'h777;
    @(posedge aclk); #1;
    resp_valid = 1'b0; resp_hit = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("idle_resp_hit",  64'({res_hit, res_paddr}), 64'(0));
    chk("idle_resp_miss", 64'(cnt_miss), 64'(mm));
    @(posedge aclk); #1;

    // Reset during WAIT, then a stale response.
    start_query(48'h6000, 6'd2);
    handshake(0, lat);
    repeat (3) @(posedge aclk); #1;
    areset = 1'b1; vaddr = '0; pid = '0;
    #1;
    chk_all_zero("rst_wait");
    exp_req.delete(); exp_res.delete();
    mq = 0; mm = 0; mt = 0;
    @(posedge aclk); #1;
    areset = 1'b0;
    resp_valid = 1'b1; resp_hit = 1'b1; resp_paddr = 40'h999;
    @(posedge aclk); #1;
    resp_valid = 1'b0; resp_hit = 1'b0;
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    chk_all_zero("stale_resp");
    @(posedge aclk); #1;

    // Nonzero key held through reset triggers one query, not in the first cycle.
    areset = 1'b1;
    vaddr = 48'h5000; pid = 6'd1;
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_req.push_back({48'h5000, 6'd1});
    handshake(0, lat);
    chk("post_rst_latency", 64'(lat), 64'(2));
    respond(4, 1'b1, 1'b1, 40'h50000);
    wait_done();

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      int mode, stall, j;
      bit hit;
      do begin
        va = VADDR_BITS'({$urandom(), $urandom()});
        p  = PID_BITS'($urandom());
      end while ({va, p} == {vaddr, pid});
      pa    = PADDR_BITS'({$urandom(), $urandom()});
      mode  = $urandom_range(0, 3);
      stall = $urandom_range(0, 3);
      hit   = 1'($urandom_range(0, 1));
      start_query(va, p);
      handshake(stall, lat);
      chk("rnd_latency", 64'(lat), 64'(2));
      case (mode)
        0:       respond($urandom_range(0, TMO - 2), 1'b1, 1'b1, pa);
        1:       respond($urandom_range(0, TMO - 2), 1'b1, 1'b0, pa);
        2:       respond(0, 1'b0, 1'b0, pa);
        default: respond(TMO - 1, 1'b1, hit, pa);
      endcase
      wait_done();
    end

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("req_queue_drained", 64'(exp_req.size()), 64'(0));
    chk("res_queue_drained", 64'(exp_res.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
